// File: rtl/calc_pkg.sv
// Shared types and the 7-segment glyph table for the calculator display path.
// Pure declarations: no latency, no flow control.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Segment order is {g,f,e,d,c,b,a}; bit0 drives segment a.
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] seg_of(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_OFF;
        if (digit <= 4'd9) begin
            seg = SEG_LUT[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble: 8-bit binary to 3 BCD digits, one shift per clock.
// bcd/bcd_valid land 9 edges after the accepting edge; strobes seen while busy are dropped.
module calc_bin2bcd
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value,
    input  logic        value_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid
);

    conv_state_t r_state;
    conv_state_t w_state_nxt;
    logic [7:0]  r_shift;
    logic [11:0] r_scratch;
    logic [2:0]  r_cnt;
    logic [11:0] r_bcd;
    logic        r_bcd_valid;
    logic [11:0] w_adj;

    // Add-3 correction on every digit that would overflow past 9 after doubling.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 3; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (value_valid) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == 3'd7) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset polarity is active-high despite the rst_n name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_scratch   <= '0;
            r_cnt       <= '0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bcd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (value_valid) begin
                        r_shift   <= value;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt                <= r_cnt + 3'd1;
                end
                DONE: begin
                    r_bcd       <= r_scratch;
                    r_bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign bcd       = r_bcd;
    assign bcd_valid = r_bcd_valid;

endmodule

// File: rtl/calc_display_driver.sv
// Shows the last converted byte in decimal on a 3-digit multiplexed 7-segment display.
// seg/dig_en lag the scan index by one clock; value_valid is ignored while busy (no queueing).
module calc_display_driver
    import calc_pkg::*;
#(
    parameter logic [23:0] REFRESH_DIV    = 24'd10_000,
    parameter logic        SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  value,
    input  logic        value_valid,
    output logic        busy,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en
);

    localparam logic [6:0] SEG_POL   = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0] SEG_RESET = SEG_LUT[0] ^ SEG_POL;

    logic [23:0] r_refresh;
    logic [1:0]  r_idx;
    logic [2:0]  r_dig_en;
    logic [6:0]  r_seg;
    logic [11:0] w_bcd;
    logic        w_wrap;
    logic [2:0]  w_dig_en_nxt;
    logic [6:0]  w_seg_nxt;

    calc_bin2bcd u_bin2bcd (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .bcd         (w_bcd),
        .bcd_valid   (bcd_valid)
    );

    assign w_wrap = (r_refresh >= REFRESH_DIV - 24'd1);

    // Leading-zero blanking: tens shows whenever hundreds or tens is non-zero.
    always_comb begin
        w_dig_en_nxt = 3'b000;
        w_seg_nxt    = SEG_OFF;
        case (r_idx)
            2'd0: begin
                w_dig_en_nxt = 3'b001;
                w_seg_nxt    = seg_of(w_bcd[3:0]);
            end
            2'd1: begin
                if (w_bcd[11:4] != 8'h00) begin
                    w_dig_en_nxt = 3'b010;
                    w_seg_nxt    = seg_of(w_bcd[7:4]);
                end
            end
            2'd2: begin
                if (w_bcd[11:8] != 4'h0) begin
                    w_dig_en_nxt = 3'b100;
                    w_seg_nxt    = seg_of(w_bcd[11:8]);
                end
            end
            default: ;
        endcase
        w_seg_nxt = w_seg_nxt ^ SEG_POL;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_refresh <= '0;
            r_idx     <= '0;
            r_dig_en  <= 3'b001;
            r_seg     <= SEG_RESET;
        end else begin
            r_dig_en <= w_dig_en_nxt;
            r_seg    <= w_seg_nxt;
            if (w_wrap) begin
                r_refresh <= '0;
                r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_refresh <= r_refresh + 24'd1;
            end
        end
    end

    assign bcd    = w_bcd;
    assign seg    = r_seg;
    assign dig_en = r_dig_en;

endmodule

// File: tb/tb_calc_display_driver.sv
// Bench for calc_display_driver: two instances (REFRESH_DIV=4 active-high, REFRESH_DIV=1 active-low)
// compared every cycle against a decimal-arithmetic reference model, plus vector table and corner sequences.
module tb_calc_display_driver;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic [7:0]  value       = '0;
    logic        value_valid = 1'b0;

    logic        busy0, busy1, bcd_valid0, bcd_valid1;
    logic [11:0] bcd0, bcd1;
    logic [6:0]  seg0, seg1;
    logic [2:0]  dig0, dig1;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    calc_display_driver #(.REFRESH_DIV(24'd4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
        .busy(busy0), .bcd(bcd0), .bcd_valid(bcd_valid0), .seg(seg0), .dig_en(dig0)
    );

    calc_display_driver #(.REFRESH_DIV(24'd1), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .value(value), .value_valid(value_valid),
        .busy(busy1), .bcd(bcd1), .bcd_valid(bcd_valid1), .seg(seg1), .dig_en(dig1)
    );

    localparam logic [6:0] GLYPH [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam int DIV [0:1] = '{4, 1};
    localparam bit AL  [0:1] = '{1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // What one scan slot should show for decimal value v.
    function automatic logic [9:0] slot(input int idx, input int v, input bit al);
        logic [2:0] en;
        logic [6:0] s;
        en = 3'b000;
        s  = 7'h00;
        case (idx)
            0: begin en = 3'b001; s = GLYPH[v % 10]; end
            1: if (v >= 10) begin en = 3'b010; s = GLYPH[(v / 10) % 10]; end
            default: if (v >= 100) begin en = 3'b100; s = GLYPH[v / 100]; end
        endcase
        if (al) s = ~s;
        return {en, s};
    endfunction

    // Reference model: conversion = 9 busy cycles then the decimal value appears.
    int         m_busy_left;
    int         m_pend;
    int         m_val;
    logic       m_bv;
    int         m_cnt [0:1];
    int         m_idx [0:1];
    logic [2:0] m_en  [0:1];
    logic [6:0] m_seg [0:1];

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            m_busy_left <= 0;
            m_pend      <= 0;
            m_val       <= 0;
            m_bv        <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] <= 0;
                m_idx[k] <= 0;
                m_en[k]  <= 3'b001;
                m_seg[k] <= AL[k] ? 7'h40 : 7'h3F;
            end
        end else begin
            m_bv <= 1'b0;
            if (m_busy_left == 0) begin
                if (value_valid) begin
                    m_busy_left <= 9;
                    m_pend      <= int'(value);
                end
            end else begin
                m_busy_left <= m_busy_left - 1;
                if (m_busy_left == 1) begin
                    m_val <= m_pend;
                    m_bv  <= 1'b1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                {m_en[k], m_seg[k]} <= slot(m_idx[k], m_val, AL[k]);
                if (m_cnt[k] == DIV[k] - 1) begin
                    m_cnt[k] <= 0;
                    m_idx[k] <= (m_idx[k] + 1) % 3;
                end else begin
                    m_cnt[k] <= m_cnt[k] + 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc busy0",  busy0,      m_busy_left != 0);
            check("cyc busy1",  busy1,      m_busy_left != 0);
            check("cyc bcd0",   bcd0,       to_bcd(m_val));
            check("cyc bcd1",   bcd1,       to_bcd(m_val));
            check("cyc bvld0",  bcd_valid0, m_bv);
            check("cyc bvld1",  bcd_valid1, m_bv);
            check("cyc dig0",   dig0,       m_en[0]);
            check("cyc seg0",   seg0,       m_seg[0]);
            check("cyc dig1",   dig1,       m_en[1]);
            check("cyc seg1",   seg1,       m_seg[1]);
        end
    end

    task automatic strobe(input logic [7:0] v);
        value       = v;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_vld(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bcd_valid0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, " vld timeout"}, seen, 1'b1);
    endtask

    // Sync to the start of a ones slot on the DIV=4 instance, then sample mid-slot for each digit.
    task automatic scan_check(input string tag,
                              input logic [2:0] e0, input logic [6:0] s0,
                              input logic [2:0] e1, input logic [6:0] s1,
                              input logic [2:0] e2, input logic [6:0] s2);
        logic [2:0] prev;
        bit found;
        found = 1'b0;
        prev  = dig0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dig0 == 3'b001 && prev != 3'b001) found = 1'b1;
            else prev = dig0;
        end
        check({tag, " scan sync"}, found, 1'b1);
        if (found) begin
            @(negedge clk);
            check({tag, " en0"}, dig0, e0);
            check({tag, " seg0"}, seg0, s0);
            repeat (4) @(negedge clk);
            check({tag, " en1"}, dig0, e1);
            check({tag, " seg1"}, seg0, s1);
            repeat (4) @(negedge clk);
            check({tag, " en2"}, dig0, e2);
            check({tag, " seg2"}, seg0, s2);
        end
    endtask

    typedef struct {
        logic [7:0]  v;
        logic [11:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [12];
        int busy_cycles, vld_at, n_vld;

        vecs[0]  = '{8'd0,   12'h000};
        vecs[1]  = '{8'd1,   12'h001};
        vecs[2]  = '{8'd9,   12'h009};
        vecs[3]  = '{8'd10,  12'h010};
        vecs[4]  = '{8'd50,  12'h050};
        vecs[5]  = '{8'd64,  12'h064};
        vecs[6]  = '{8'd99,  12'h099};
        vecs[7]  = '{8'd100, 12'h100};
        vecs[8]  = '{8'd128, 12'h128};
        vecs[9]  = '{8'd199, 12'h199};
        vecs[10] = '{8'd254, 12'h254};
        vecs[11] = '{8'd255, 12'h255};

        // Reset state, then tens blanking of a zero display.
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b0;
        chk_en = 1'b1;
        check("rst busy",   busy0,      1'b0);
        check("rst bcd",    bcd0,       12'h000);
        check("rst bvld",   bcd_valid0, 1'b0);
        check("rst dig",    dig0,       3'b001);
        check("rst seg",    seg0,       7'h3F);
        check("rst seg al", seg1,       7'h40);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("zero tens dig", dig0, 3'b000);
        check("zero tens seg", seg0, 7'h00);

        // 255: busy duration and bcd_valid timing.
        @(negedge clk);
        value       = 8'd255;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        busy_cycles = 0;
        vld_at      = -1;
        n_vld       = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy0) busy_cycles++;
            if (bcd_valid0) begin
                n_vld++;
                vld_at = i;
            end
            @(negedge clk);
        end
        check("255 busy cycles", busy_cycles, 9);
        check("255 vld edge",    vld_at,      9);
        check("255 vld pulses",  n_vld,       1);
        check("255 bcd",         bcd0,        12'h255);
        scan_check("255", 3'b001, 7'h6D, 3'b010, 7'h6D, 3'b100, 7'h5B);

        strobe(8'd7);
        wait_vld("7");
        scan_check("7", 3'b001, 7'h07, 3'b000, 7'h00, 3'b000, 7'h00);

        strobe(8'd105);
        wait_vld("105");
        check("105 bcd", bcd0, 12'h105);
        scan_check("105", 3'b001, 7'h6D, 3'b010, 7'h3F, 3'b100, 7'h06);

        // Strobe during busy is dropped; strobe right after busy falls is taken.
        strobe(8'd200);
        @(negedge clk);
        @(negedge clk);
        strobe(8'd9);
        wait_vld("200");
        check("drop bcd",  bcd0,  12'h200);
        check("drop busy", busy0, 1'b0);
        strobe(8'd9);
        check("b2b busy", busy0, 1'b1);
        wait_vld("b2b");
        check("b2b bcd", bcd0, 12'h009);

        for (int i = 0; i < 12; i++) begin
            strobe(vecs[i].v);
            wait_vld("tbl");
            check("tbl bcd", bcd0, vecs[i].exp);
        end

        // Asynchronous reset mid-conversion.
        strobe(8'd123);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("arst busy",   busy0, 1'b0);
        check("arst bcd",    bcd0,  12'h000);
        check("arst bcd al", bcd1,  12'h000);
        check("arst dig",    dig0,  3'b001);
        check("arst seg",    seg0,  7'h3F);
        check("arst seg al", seg1,  7'h40);
        @(negedge clk);
        rst_n = 1'b0;
        n_vld = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bcd_valid0 || bcd_valid1) n_vld++;
        end
        check("arst no vld", n_vld, 0);

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            value       = 8'($urandom);
            value_valid = ($urandom_range(0, 3) == 0);
            rst_n       = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        value_valid = 1'b0;
        rst_n       = 1'b0;
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
